// File: rtl/fft_pkg.sv
// Shared types and elaboration helpers for the FFT engine.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD
  } fft_state_e;

  localparam int DEF_DATA_W = 16;

  typedef struct packed {
    logic signed [DEF_DATA_W-1:0] re;
    logic signed [DEF_DATA_W-1:0] im;
  } cplx_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Reverses the low 'bits' bits of v; upper bits of the result are zero.
  function automatic logic [15:0] bitrev(input logic [15:0] v, input int bits);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < bits) r[i] = v[bits-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_engine_if.sv
// Sample-in, result-out and twiddle-lookup signals of the FFT engine.
interface fft_engine_if
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16
);
  localparam int TWA_W = clog2(N_POINTS) - 1;

  logic                     InValid;
  logic                     InReady;
  logic signed [DATA_W-1:0] InReal;
  logic signed [DATA_W-1:0] InImag;
  logic                     OutValid;
  logic                     OutReady;
  logic signed [DATA_W-1:0] OutReal;
  logic signed [DATA_W-1:0] OutImag;
  logic                     OutLast;
  logic        [TWA_W-1:0]  TwAddr;
  logic signed [TW_W-1:0]   TwReal;
  logic signed [TW_W-1:0]   TwImag;

  modport slave (
    input  InValid, InReal, InImag, OutReady, TwReal, TwImag,
    output InReady, OutValid, OutReal, OutImag, OutLast, TwAddr
  );

  modport master (
    output InValid, InReal, InImag, OutReady, TwReal, TwImag,
    input  InReady, OutValid, OutReal, OutImag, OutLast, TwAddr
  );

endinterface

// File: rtl/fft_butterfly.sv
// Radix-2 DIT butterfly: rounded complex twiddle product, add/sub, wrap to DATA_W.
// FFT_STAGE_SCALE_EN: halve (floor) both results before truncation.
module fft_butterfly #(
  parameter int DATA_W = 16,
  parameter int TW_W   = 16
) (
  input  logic signed [DATA_W-1:0] a_re_i,
  input  logic signed [DATA_W-1:0] a_im_i,
  input  logic signed [DATA_W-1:0] b_re_i,
  input  logic signed [DATA_W-1:0] b_im_i,
  input  logic signed [TW_W-1:0]   w_re_i,
  input  logic signed [TW_W-1:0]   w_im_i,
  output logic signed [DATA_W-1:0] top_re_o,
  output logic signed [DATA_W-1:0] top_im_o,
  output logic signed [DATA_W-1:0] bot_re_o,
  output logic signed [DATA_W-1:0] bot_im_o
);
  localparam int PW = DATA_W + TW_W + 1;
  localparam logic signed [PW-1:0] RND = PW'(1) <<< (TW_W - 2);

  logic signed [PW-1:0] br, bi, wr, wi, ar, ai;
  logic signed [PW-1:0] pr_full, pi_full, pr, pi;
  logic signed [PW-1:0] tr, ti, xr, xi;

  always_comb begin
    br = PW'(b_re_i);
    bi = PW'(b_im_i);
    wr = PW'(w_re_i);
    wi = PW'(w_im_i);
    ar = PW'(a_re_i);
    ai = PW'(a_im_i);
    pr_full = br * wr - bi * wi;
    pi_full = br * wi + bi * wr;
    // Round half up in Q1.(TW_W-1) before dropping the fraction bits.
    pr = (pr_full + RND) >>> (TW_W - 1);
    pi = (pi_full + RND) >>> (TW_W - 1);
    tr = ar + pr;
    ti = ai + pi;
    xr = ar - pr;
    xi = ai - pi;
`ifdef FFT_STAGE_SCALE_EN
    top_re_o = DATA_W'(tr >>> 1);
    top_im_o = DATA_W'(ti >>> 1);
    bot_re_o = DATA_W'(xr >>> 1);
    bot_im_o = DATA_W'(xi >>> 1);
`else
    top_re_o = DATA_W'(tr);
    top_im_o = DATA_W'(ti);
    bot_re_o = DATA_W'(xr);
    bot_im_o = DATA_W'(xi);
`endif
  end

endmodule

// File: rtl/fft_engine.sv
// In-place radix-2 DIT FFT: bit-reversed load, one butterfly per cycle, natural-order unload.
// FFT_STAGE_SCALE_EN selects per-stage 1/2 scaling inside fft_butterfly.
module fft_engine
  import fft_pkg::*;
#(
  parameter int N_POINTS = 16,
  parameter int DATA_W   = 16,
  parameter int TW_W     = 16
) (
  input  logic         Clock,
  input  logic         Areset,
  input  logic         Start,
  output logic         Busy,
  output logic         Done,
  fft_engine_if.slave  bus
);
  localparam int L  = clog2(N_POINTS);
  localparam int KW = L - 1;
  localparam logic [L-1:0]  CNT_LAST = L'(N_POINTS - 1);
  localparam logic [L-1:0]  STG_LAST = L'(L - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(N_POINTS / 2 - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } sample_t;

  fft_state_e state_q, state_d;
  logic [L-1:0]  cnt_q, cnt_d;
  logic [L-1:0]  stage_q, stage_d;
  logic [KW-1:0] bfly_q, bfly_d;
  logic          done_q, done_d;
  logic          load_we, bf_we, out_valid;

  sample_t mem [N_POINTS];

  logic [L-1:0]  load_addr, top_addr, bot_addr, k_ext, k_mask;
  logic [KW-1:0] tw_addr;
  sample_t       a_word, b_word, out_word;
  logic signed [DATA_W-1:0] top_re, top_im, bot_re, bot_im;

  always_ff @(posedge Clock) begin
    if (Areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stage_q <= '0;
      bfly_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stage_q <= stage_d;
      bfly_q  <= bfly_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stage_d = stage_q;
    bfly_d  = bfly_q;
    done_d  = 1'b0;
    load_we = 1'b0;
    bf_we   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (bus.InValid) begin
          load_we = 1'b1;
          cnt_d   = cnt_q + L'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = COMPUTE;
            cnt_d   = '0;
            stage_d = '0;
            bfly_d  = '0;
          end
        end
      end
      COMPUTE: begin
        bf_we  = 1'b1;
        bfly_d = bfly_q + KW'(1);
        if (bfly_q == K_LAST) begin
          stage_d = stage_q + L'(1);
          if (stage_q == STG_LAST) begin
            state_d = UNLOAD;
            cnt_d   = '0;
          end
        end
      end
      UNLOAD: begin
        if (bus.OutReady) begin
          cnt_d = cnt_q + L'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Butterfly k of stage s: top = (k>>s)*2h + (k mod h), bot = top + h, W index (k mod h) << (L-1-s).
  always_comb begin
    k_ext     = L'(bfly_q);
    k_mask    = (L'(1) << stage_q) - L'(1);
    top_addr  = ((k_ext >> stage_q) << (stage_q + L'(1))) | (k_ext & k_mask);
    bot_addr  = top_addr | (L'(1) << stage_q);
    tw_addr   = KW'((k_ext & k_mask) << (L'(KW) - stage_q));
    load_addr = L'(bitrev(16'(cnt_q), L));
  end

  assign a_word   = mem[top_addr];
  assign b_word   = mem[bot_addr];
  assign out_word = mem[cnt_q];

  fft_butterfly #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W)
  ) u_butterfly (
    .a_re_i   (a_word.re),
    .a_im_i   (a_word.im),
    .b_re_i   (b_word.re),
    .b_im_i   (b_word.im),
    .w_re_i   (bus.TwReal),
    .w_im_i   (bus.TwImag),
    .top_re_o (top_re),
    .top_im_o (top_im),
    .bot_re_o (bot_re),
    .bot_im_o (bot_im)
  );

  // Sample storage carries no reset; every transform rewrites all N words before use.
  always_ff @(posedge Clock) begin
    if (load_we) begin
      mem[load_addr] <= '{re: bus.InReal, im: bus.InImag};
    end
    if (bf_we) begin
      mem[top_addr] <= '{re: top_re, im: top_im};
      mem[bot_addr] <= '{re: bot_re, im: bot_im};
    end
  end

  assign out_valid    = (state_q == UNLOAD);
  assign Busy         = (state_q != IDLE);
  assign Done         = done_q;
  assign bus.InReady  = (state_q == LOAD);
  assign bus.OutValid = out_valid;
  assign bus.OutLast  = out_valid && (cnt_q == CNT_LAST);
  assign bus.OutReal  = out_valid ? out_word.re : '0;
  assign bus.OutImag  = out_valid ? out_word.im : '0;
  assign bus.TwAddr   = (state_q == COMPUTE) ? tw_addr : '0;

endmodule

// File: doc/fft_engine.md
FFT_ENGINE -- requirements
Module: fft_engine

Interface
REQ-001 SHALL have parameter N_POINTS, default 16, meaning transform length (power of two, 4..1024).
REQ-002 SHALL have parameter DATA_W, default 16, meaning signed two's-complement width of each real and imaginary sample.
REQ-003 SHALL have parameter TW_W, default 16, meaning signed Q1.(TW_W-1) twiddle width.
REQ-004 SHALL have port Clock  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port Areset  in  1  synchronous, active-high reset.
REQ-006 SHALL have port Start  in  1  request to begin a transform.
REQ-007 SHALL have ports InValid in 1 / InReady out 1 / InReal in DATA_W / InImag in DATA_W  input sample stream.
REQ-008 SHALL have ports OutValid out 1 / OutReady in 1 / OutReal out DATA_W / OutImag out DATA_W / OutLast out 1  result stream.
REQ-009 SHALL have ports TwAddr out log2(N_POINTS)-1 / TwReal in TW_W / TwImag in TW_W  twiddle lookup; the external table returns W^k = cos(2πk/N) - j·sin(2πk/N) combinationally in the same cycle.
REQ-010 SHALL have ports Busy out 1 (state != IDLE) and Done out 1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement an FSM with states IDLE, LOAD, COMPUTE and UNLOAD.
REQ-012 IDLE: Start=1 SHALL move to LOAD next cycle; Start in any other state SHALL be ignored.
REQ-013 LOAD: InReady=1; each InValid&&InReady SHALL write the sample to mem[bitrev(count)], count 0..N-1; after the N-th accept, the FSM SHALL enter COMPUTE next cycle and InReady SHALL drop.
REQ-014 COMPUTE: exactly one radix-2 DIT butterfly per cycle; L=log2(N) stages x N/2 butterflies; total L·N/2 cycles, then UNLOAD.
REQ-015 Butterfly k of stage s (h=2^s): top=(k>>s)·2h+(k&(h-1)), bot=top+h, TwAddr=(k&(h-1))<<(L-1-s); reads and writes of both words SHALL occur in the same cycle.
REQ-016 Arithmetic: p = mem[bot]·W as a full complex product (DATA_W+TW_W+1 bits), rounded by adding 2^(TW_W-2) then arithmetic right shift TW_W-1; mem[top]=a+p, mem[bot]=a-p, each truncated (wrapped) to DATA_W.
REQ-017 UNLOAD: OutValid=1, Out* = mem[count] in natural order; count SHALL advance only on OutValid&&OutReady; OutLast=1 when count=N-1.
REQ-018 When OutReady=0, Out* SHALL hold stable.
REQ-019 After the last accept, the FSM SHALL move to IDLE and Done SHALL pulse high for exactly one cycle.
REQ-020 TwAddr SHALL be 0 outside COMPUTE.

Reset
REQ-021 Areset=1 SHALL, at the next edge, set state=IDLE, all counters to 0, and InReady, OutValid, OutLast, Busy and Done to 0, from any state, including mid-LOAD and mid-COMPUTE.
REQ-022 Memory contents SHALL NOT be reset; outputs SHALL never expose stale memory while OutValid=0.

Configuration
REQ-023 Macro FFT_STAGE_SCALE_EN defined: each butterfly result SHALL be arithmetic-shifted right by 1 (floor) before writeback, for a total scale of 1/N with no overflow.
REQ-024 FFT_STAGE_SCALE_EN undefined: no scaling; results SHALL wrap per REQ-016.

Structure
REQ-025 Package fft_pkg SHALL hold the state enum, the complex sample struct (re/im, DATA_W) and the function clog2/bitrev helpers.
REQ-026 SHALL instantiate a single combinational sub-module, fft_butterfly (complex multiply, round, add/sub, optional scale), once.

Verification
REQ-027 Impulse x[0]=1000+0j, rest 0, no scale, N=16 -> all 16 outputs 1000+0j; with FFT_STAGE_SCALE_EN -> all 62+0j.
REQ-028 DC: all x=100+0j, no scale -> X[0]=1600+0j, X[1..15]=0; Done pulses once, exactly one cycle after the OutLast accept.
REQ-029 Cycle count: Start to the first OutValid = 1 + 16 (load, InValid constant) + 32 compute cycles for N=16; TwAddr=0 for all of stage 0 and equals 0,4 repeating in stage 1.
REQ-030 Backpressure: OutReady toggled 0/1 per cycle -> the output sequence is identical to the no-stall run, and data holds during stalls.
REQ-031 Areset asserted for one cycle mid-COMPUTE -> next cycle Busy=0, OutValid=0; a subsequent full transform is correct.
REQ-032 Start pulsed during LOAD and UNLOAD -> no effect on counts or results.
